spi_master: RTL
===============

# spi_master

Single-byte SPI master (mode 0, MSB first) that generates chip-select, serial clock and serial data-out for an attached SPI slave and captures the slave's returned byte. It sits between the system-side control logic (start/data/done handshake on the system clock) and the four-wire SPI pins. All SPI signals are derived from the system clock by an internal half-period divider.

## Interface

- HALF_PERIOD, 4, system clock cycles per SCLK half-period; legal range 1..255
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a transfer; accepted only when busy=0
- tx_data  input  8  byte to transmit; captured on the accepting cycle
- cs  output  1  chip select, active low
- sclk  output  1  serial clock, idle low
- mosi  output  1  serial data to slave
- miso  input  1  serial data from slave
- rx_data  output  8  last received byte; updated only on done
- busy  output  1  transfer or inter-frame gap in progress
- done  output  1  one-cycle pulse at end of transfer

## Operation

- States: IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, GAP.
- IDLE: cs=1, sclk=0, busy=0. start=1 -> latch tx_data into tx shift register, go SETUP.
- SETUP: cs=0, mosi=tx_data[7], sclk=0; lasts HALF_PERIOD cycles -> SCLK_HI.
- SCLK_HI: sclk=1 for HALF_PERIOD cycles. On the cycle sclk rises, sample miso into rx shift register LSB (shift left). -> SCLK_LO.
- SCLK_LO: sclk=0 for HALF_PERIOD cycles. On entry, if bits remain, mosi takes next bit (MSB first); after the 8th falling edge mosi holds bit 0. Bit counter 3 bits; after 8th SCLK_LO -> HOLD, else -> SCLK_HI.
- HOLD: cs=0, sclk=0 for HALF_PERIOD cycles -> GAP.
- GAP: cs=1; on entry done=1 for one cycle, rx_data <= rx shift register. Lasts HALF_PERIOD cycles, busy=1 -> IDLE.
- start while busy=1: ignored, tx_data not captured.
- Half-period counter width ceil(log2(HALF_PERIOD+1)); counts 0..HALF_PERIOD-1, wraps to 0 on every state change.
- Exactly 8 rising and 8 falling SCLK edges per frame; no SCLK edges while cs=1.
- miso is sampled directly; no synchroniser (SCLK is generated locally, setup margin = HALF_PERIOD-1 clk cycles).

## Timing

- Reset values: cs=1, sclk=0, mosi=0, rx_data=8'h00, busy=0, done=0; state IDLE; counters 0.
- rst asserted mid-transfer: all outputs take reset values immediately (async); no done pulse; rx_data unchanged from 8'h00 reset value.
- Let H=HALF_PERIOD, start accepted at cycle 0 edge. cs falls and busy rises at cycle 1; sclk first rises at cycle 1+H; rises at 1+H+2kH (k=0..7); falls at 1+2H+2kH.
- cs low for exactly 18H cycles (cycles 1..18H); cs rises, done=1, rx_data valid at cycle 18H+1.
- busy high cycles 1..19H; busy=0 and next start accepted at cycle 19H+1 at earliest. Frame-to-frame period 19H+1 cycles.
- mosi stable for H cycles before each rising sclk edge and H cycles after it.
- done and busy never both low during a frame; done coincides with busy=1.

## Test plan

- Loopback (miso=mosi), H=4, tx_data=8'hA5 -> done after 73 cycles, rx_data=8'hA5, cs low exactly 72 cycles, 8 sclk rising edges.
- Behavioural mode-0 slave returning 8'h3C, tx_data=8'hC3 -> slave receives 8'hC3, rx_data=8'h3C, mosi bit order 1,1,0,0,0,0,1,1.
- start pulsed again mid-frame with tx_data=8'hFF -> ignored; frame completes with original byte; single done pulse.
- Back-to-back: start held high, tx 8'h01 then 8'h80 -> second cs falls exactly 19H+1 cycles after first; cs high ≥H cycles between frames.
- rst asserted after 3rd rising sclk edge -> cs=1, sclk=0, mosi=0, busy=0 same cycle; no done; next start runs a clean full frame.
- H=1, loopback 8'h5A -> cs low 18 cycles, rx_data=8'h5A, sclk toggles every cycle.

Source files
------------

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0, MSB first. All SPI timing comes from a
// HALF_PERIOD-cycle divider on the system clock; one IDLE cycle separates frames.
module spi_master #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done
);

  localparam int            CW   = $clog2(HALF_PERIOD + 1);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr, rx_sr;
  logic          half_end;

  assign half_end = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = SETUP;
      SETUP:   if (half_end) state_nxt = SCLK_HI;
      SCLK_HI: if (half_end) state_nxt = SCLK_LO;
      SCLK_LO: if (half_end) state_nxt = (bit_cnt == 3'd7) ? HOLD : SCLK_HI;
      HOLD:    if (half_end) state_nxt = GAP;
      GAP:     if (half_end) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Pin outputs decode straight from state so cs/sclk/busy move together.
  assign cs   = (state == IDLE) || (state == GAP);
  assign sclk = (state == SCLK_HI);
  assign busy = (state != IDLE);
  assign mosi = tx_sr[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= (state == IDLE || state_nxt != state) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          tx_sr   <= tx_data;
          bit_cnt <= '0;
        end
        SCLK_HI: begin
          // miso sampled in the first high cycle; slave drove it a half-period earlier
          if (cnt == '0) rx_sr <= {rx_sr[6:0], miso};
          // next bit presented on the falling edge; bit 0 is held after the last one
          if (half_end && bit_cnt != 3'd7) tx_sr <= {tx_sr[6:0], 1'b0};
        end
        SCLK_LO: if (half_end && bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
        HOLD: if (half_end) begin
          rx_data <= rx_sr;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
